mem_arbiter: RTL and testbench

Round-robin arbiter that shares one external memory channel (read + write ports) among `NUM_CONSUMERS` requesters: the LSUs and instruction fetchers of all cores. Sits between the cores and the off-chip data/program memory interface. One transaction is in flight at a time. The consumer-side valid/ready handshake is held until the consumer withdraws its request.

---
 rtl/gpu_mem_pkg.sv | 16 +
 rtl/rr_picker.sv | 33 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the memory-channel arbiter: FSM state encoding and
// default memory address/data widths.
package gpu_mem_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ_WAIT   = 3'd1,
    WRITE_WAIT  = 3'd2,
    READ_RELAY  = 3'd3,
    WRITE_RELAY = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr_i, wrapping from N-1 back to 0. Works for any N >= 2, power of two or not.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] cand;

  // Walk the N candidates in priority order; the one extra bit holds ptr+k
  // before the explicit wrap so non-power-of-two N folds back correctly.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found_o && req_i[cand[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel among
// NUM_CONSUMERS requesters, one transaction in flight at a time.
//
// Handshake: a consumer raises *_valid (with address/data) and keeps it high
// until it sees its *_ready. Ready then stays high until the consumer drops
// valid; the cycle valid is seen low ends the transaction. On the memory side
// mem_*_valid is held with a stable address until mem_*_ready is sampled high;
// mem_*_ready is ignored in every other state.
module mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int NUM_CONSUMERS = 4,
  parameter int ID_BITS       = $clog2(NUM_CONSUMERS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic [ID_BITS-1:0]                 grant_id,
  output logic [2:0]                         debug_state
);

  arb_state_t                         state_q;
  logic [ID_BITS-1:0]                 rr_ptr_q;
  logic [ID_BITS-1:0]                 grant_id_q;
  logic                               mem_read_valid_q;
  logic [ADDR_BITS-1:0]               mem_read_address_q;
  logic                               mem_write_valid_q;
  logic [ADDR_BITS-1:0]               mem_write_address_q;
  logic [DATA_BITS-1:0]               mem_write_data_q;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_q;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_q;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_q;

  logic               pick_found;
  logic [ID_BITS-1:0] pick_idx;
  logic [ID_BITS-1:0] rr_ptr_d;

  rr_picker #(
    .N  (NUM_CONSUMERS),
    .IW (ID_BITS)
  ) u_picker (
    .req_i   (consumer_read_valid | consumer_write_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // The served consumer moves to lowest priority for the next search.
  assign rr_ptr_d = (grant_id_q == ID_BITS'(NUM_CONSUMERS-1)) ? '0 : grant_id_q + 1'b1;

  // Arbitration FSM with all outputs registered; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q                <= IDLE;
      rr_ptr_q               <= '0;
      grant_id_q             <= '0;
      mem_read_valid_q       <= 1'b0;
      mem_read_address_q     <= '0;
      mem_write_valid_q      <= 1'b0;
      mem_write_address_q    <= '0;
      mem_write_data_q       <= '0;
      consumer_read_ready_q  <= '0;
      consumer_write_ready_q <= '0;
      consumer_read_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q <= pick_idx;
            // A consumer holding both valids has its read served first.
            if (consumer_read_valid[pick_idx]) begin
              mem_read_valid_q   <= 1'b1;
              mem_read_address_q <= consumer_read_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
              state_q            <= READ_WAIT;
            end else begin
              mem_write_valid_q   <= 1'b1;
              mem_write_address_q <= consumer_write_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
              mem_write_data_q    <= consumer_write_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
              state_q             <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            consumer_read_data_q[int'(grant_id_q)*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready_q[grant_id_q] <= 1'b1;
            mem_read_valid_q                  <= 1'b0;
            state_q                           <= READ_RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            consumer_write_ready_q[grant_id_q] <= 1'b1;
            mem_write_valid_q                  <= 1'b0;
            state_q                            <= WRITE_RELAY;
          end
        end
        READ_RELAY: begin
          if (!consumer_read_valid[grant_id_q]) begin
            consumer_read_ready_q[grant_id_q] <= 1'b0;
            rr_ptr_q                          <= rr_ptr_d;
            state_q                           <= IDLE;
          end
        end
        WRITE_RELAY: begin
          if (!consumer_write_valid[grant_id_q]) begin
            consumer_write_ready_q[grant_id_q] <= 1'b0;
            rr_ptr_q                           <= rr_ptr_d;
            state_q                            <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign consumer_read_ready  = consumer_read_ready_q;
  assign consumer_write_ready = consumer_write_ready_q;
  assign consumer_read_data   = consumer_read_data_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;
  assign grant_id             = grant_id_q;
  assign debug_state          = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 4-consumer instance exercised by directed and
// randomized traffic against a transaction-level round-robin model, plus a
// 3-consumer instance for the non-power-of-two wrap.
module tb_mem_arbiter;
  import gpu_mem_pkg::*;

  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT (N=4) ----------------
  logic [N-1:0]   consumer_read_valid;
  logic [N*A-1:0] consumer_read_address;
  logic [N-1:0]   consumer_read_ready;
  logic [N*D-1:0] consumer_read_data;
  logic [N-1:0]   consumer_write_valid;
  logic [N*A-1:0] consumer_write_address;
  logic [N*D-1:0] consumer_write_data;
  logic [N-1:0]   consumer_write_ready;
  logic           mem_read_valid;
  logic [A-1:0]   mem_read_address;
  logic           mem_read_ready;
  logic [D-1:0]   mem_read_data;
  logic           mem_write_valid;
  logic [A-1:0]   mem_write_address;
  logic [D-1:0]   mem_write_data;
  logic           mem_write_ready;
  logic [1:0]     grant_id;
  logic [2:0]     debug_state;

  mem_arbiter #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .grant_id(grant_id), .debug_state(debug_state)
  );

  // ---------------- DUT (N=3) ----------------
  logic [2:0]  rv3;
  logic [23:0] zero_a3 = '0;
  logic [23:0] zero_d3 = '0;
  logic [2:0]  zero_v3 = '0;
  logic [2:0]  consumer_read_ready3, consumer_write_ready3;
  logic [23:0] consumer_read_data3;
  logic        mem_read_valid3, mem_write_valid3;
  logic [7:0]  mem_read_address3, mem_write_address3, mem_write_data3;
  logic        mem_read_ready3 = 1'b1;
  logic        mem_write_ready3 = 1'b1;
  logic [7:0]  mem_read_data3 = 8'h5A;
  logic [1:0]  grant_id3;
  logic [2:0]  debug_state3;

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(3)) dut3 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv3), .consumer_read_address(zero_a3),
    .consumer_read_ready(consumer_read_ready3), .consumer_read_data(consumer_read_data3),
    .consumer_write_valid(zero_v3), .consumer_write_address(zero_a3),
    .consumer_write_data(zero_d3), .consumer_write_ready(consumer_write_ready3),
    .mem_read_valid(mem_read_valid3), .mem_read_address(mem_read_address3),
    .mem_read_ready(mem_read_ready3), .mem_read_data(mem_read_data3),
    .mem_write_valid(mem_write_valid3), .mem_write_address(mem_write_address3),
    .mem_write_data(mem_write_data3), .mem_write_ready(mem_write_ready3),
    .grant_id(grant_id3), .debug_state(debug_state3)
  );

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;

  logic [N-1:0] rv, wv;
  logic [A-1:0] rd_addr [N];
  logic [A-1:0] wr_addr [N];
  logic [D-1:0] wr_data [N];
  int           rp [N];
  int           wp [N];
  bit           early [N];
  logic [D-1:0] mem_model [256];
  logic [D-1:0] exp_q [$];
  int           grant_log [$];
  int           ptr_m, cur, wait_cnt, force_wait;
  bit           cur_is_rd, busy, waiting, acc, relay_chk, prev_mv, rand_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ports();
    consumer_read_valid  = rv;
    consumer_write_valid = wv;
    for (int i = 0; i < N; i++) begin
      consumer_read_address[i*A +: A]  = rd_addr[i];
      consumer_write_address[i*A +: A] = wr_addr[i];
      consumer_write_data[i*D +: D]    = wr_data[i];
    end
  endtask

  task automatic clear_model();
    rv = '0; wv = '0;
    for (int i = 0; i < N; i++) begin
      rp[i] = 0; wp[i] = 0; early[i] = 1'b0;
    end
    exp_q.delete();
    ptr_m = 0; cur = 0; wait_cnt = 0;
    cur_is_rd = 1'b0; busy = 1'b0; waiting = 1'b0; acc = 1'b0;
    relay_chk = 1'b0; prev_mv = 1'b0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    drive_ports();
  endtask

  // One clock of the whole environment: observe, check, then drive consumers and memory.
  task automatic cycle();
    logic [N-1:0] req, oh;
    logic [D-1:0] s, e;
    int  w;
    bit  found;
    @(posedge clk); #1;
    chk("rd_wr_exclusive", 32'(mem_read_valid & mem_write_valid), 32'd0);
    if (relay_chk) begin
      chk("ready_released_rd", 32'(consumer_read_ready), 32'd0);
      chk("ready_released_wr", 32'(consumer_write_ready), 32'd0);
      relay_chk = 1'b0;
      busy      = 1'b0;
    end
    if (acc) begin
      acc = 1'b0;
      oh  = 1;
      oh  = oh << cur;
      if (cur_is_rd) begin
        e = exp_q.pop_front();
        s = consumer_read_data[cur*D +: D];
        chk("rd_ready", 32'(consumer_read_ready), 32'(oh));
        chk("rd_no_wr_ready", 32'(consumer_write_ready), 32'd0);
        chk("mem_rd_valid_dropped", 32'(mem_read_valid), 32'd0);
        chk("rd_data", 32'(s), 32'(e));
        rv[cur] = 1'b0;
      end else begin
        chk("wr_ready", 32'(consumer_write_ready), 32'(oh));
        chk("wr_no_rd_ready", 32'(consumer_read_ready), 32'd0);
        chk("mem_wr_valid_dropped", 32'(mem_write_valid), 32'd0);
        wv[cur] = 1'b0;
      end
      relay_chk = 1'b1;
    end
    if ((mem_read_valid | mem_write_valid) && !prev_mv) begin
      req = rv | wv;
      found = 1'b0;
      w = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr_m + k) % N;
        if (!found && req[c]) begin
          found = 1'b1;
          w = c;
        end
      end
      chk("grant_has_requester", 32'(found), 32'd1);
      if (found) begin
        chk("grant_id", 32'(grant_id), 32'(w));
        chk("grant_is_read", 32'(mem_read_valid), 32'(rv[w]));
        chk("grant_is_write", 32'(mem_write_valid), 32'(!rv[w]));
        if (rv[w]) begin
          chk("mem_rd_addr", 32'(mem_read_address), 32'(rd_addr[w]));
        end else begin
          chk("mem_wr_addr", 32'(mem_write_address), 32'(wr_addr[w]));
          chk("mem_wr_data", 32'(mem_write_data), 32'(wr_data[w]));
        end
        cur       = w;
        cur_is_rd = rv[w];
        ptr_m     = (w + 1) % N;
        grant_log.push_back(w);
        busy      = 1'b1;
        waiting   = 1'b1;
        wait_cnt  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        if (early[w] && cur_is_rd) rv[w] = 1'b0;
      end
    end
    prev_mv = mem_read_valid | mem_write_valid;
    // memory responder
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    if (waiting) begin
      if (wait_cnt == 0) begin
        waiting = 1'b0;
        acc     = 1'b1;
        if (cur_is_rd) begin
          mem_read_data  = mem_model[rd_addr[cur]];
          exp_q.push_back(mem_model[rd_addr[cur]]);
          mem_read_ready = 1'b1;
        end else begin
          mem_model[wr_addr[cur]] = wr_data[cur];
          mem_write_ready = 1'b1;
        end
      end else begin
        wait_cnt--;
      end
    end
    // consumers
    for (int i = 0; i < N; i++) begin
      if (!rv[i] && rp[i] > 0 && !(busy && cur == i && cur_is_rd)) begin
        rv[i] = 1'b1;
        rp[i]--;
        if (rand_addr) rd_addr[i] = 8'($urandom_range(0, 255));
      end
      if (!wv[i] && wp[i] > 0 && !(busy && cur == i && !cur_is_rd)) begin
        wv[i] = 1'b1;
        wp[i]--;
        if (rand_addr) begin
          wr_addr[i] = 8'($urandom_range(0, 255));
          wr_data[i] = 8'($urandom_range(0, 255));
        end
      end
    end
    drive_ports();
  endtask

  function automatic bit all_done();
    bit d;
    d = (rv == '0) && (wv == '0) && !busy && !acc && !relay_chk;
    for (int i = 0; i < N; i++) if (rp[i] != 0 || wp[i] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!all_done() && n < limit) begin
      cycle();
      n++;
    end
    chk(tag, 32'(all_done()), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst_mem_rd_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_mem_wr_valid", 32'(mem_write_valid), 32'd0);
    chk("rst_mem_rd_addr", 32'(mem_read_address), 32'd0);
    chk("rst_mem_wr_addr", 32'(mem_write_address), 32'd0);
    chk("rst_mem_wr_data", 32'(mem_write_data), 32'd0);
    chk("rst_rd_ready", 32'(consumer_read_ready), 32'd0);
    chk("rst_wr_ready", 32'(consumer_write_ready), 32'd0);
    chk("rst_rd_data", 32'(consumer_read_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_state", 32'(debug_state), 32'(IDLE));
    clear_model();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int log3 [$];
    logic prev3;
    int n3;
    reset = 1'b1;
    rv3 = '0;
    force_wait = -1;
    rand_addr = 1'b0;
    mem_read_data = '0;
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
    end
    for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom_range(0, 255));
    clear_model();
    do_reset();

    // single read: consumer 2, address 0x3C, two memory wait cycles
    mem_model[8'h3C] = 8'hA5;
    rd_addr[2] = 8'h3C;
    rp[2] = 1;
    force_wait = 2;
    grant_log.delete();
    run_until_done("single_read_done", 50);
    chk("single_read_grant", 32'(grant_log[0]), 32'd2);
    chk("single_read_slice2", 32'(consumer_read_data[2*D +: D]), 32'hA5);
    chk("single_read_grant_count", 32'(grant_log.size()), 32'd1);

    // round-robin from reset with every consumer requesting
    do_reset();
    force_wait = -1;
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = 8'(8'h40 + i);
      rp[i] = 2;
    end
    grant_log.delete();
    run_until_done("rr_done", 200);
    chk("rr_g0", 32'(grant_log[0]), 32'd0);
    chk("rr_g1", 32'(grant_log[1]), 32'd1);
    chk("rr_g2", 32'(grant_log[2]), 32'd2);
    chk("rr_g3", 32'(grant_log[3]), 32'd3);
    chk("rr_g4", 32'(grant_log[4]), 32'd0);

    // write from consumer 1 racing a read of the same address by consumer 3
    wr_addr[1] = 8'h10;
    wr_data[1] = 8'h7E;
    wp[1] = 1;
    rd_addr[3] = 8'h10;
    rp[3] = 1;
    grant_log.delete();
    run_until_done("write_done", 100);
    chk("write_first", 32'(grant_log[0]), 32'd1);
    chk("read_second", 32'(grant_log[1]), 32'd3);
    chk("read_sees_write", 32'(consumer_read_data[3*D +: D]), 32'h7E);

    // consumer 0 withdraws its read while the memory is still busy
    rd_addr[0] = 8'h22;
    rp[0] = 1;
    early[0] = 1'b1;
    force_wait = 3;
    run_until_done("early_withdraw_done", 50);
    chk("early_withdraw_idle", 32'(debug_state), 32'(IDLE));
    early[0] = 1'b0;
    force_wait = -1;

    // randomized mixed traffic
    rand_addr = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        rp[i] = int'($urandom_range(0, 2));
        wp[i] = int'($urandom_range(0, 1));
        early[i] = ($urandom_range(0, 3) == 0);
      end
      run_until_done("random_round_done", 400);
    end
    for (int i = 0; i < N; i++) early[i] = 1'b0;
    rand_addr = 1'b0;

    // reset in the middle of a write
    wr_addr[1] = 8'h99;
    wr_data[1] = 8'h33;
    wp[1] = 1;
    force_wait = 20;
    repeat (3) cycle();
    chk("pre_rst_state", 32'(debug_state), 32'(WRITE_WAIT));
    chk("pre_rst_wr_valid", 32'(mem_write_valid), 32'd1);
    do_reset();
    force_wait = -1;
    rp[3] = 1;
    rp[1] = 1;
    grant_log.delete();
    run_until_done("post_rst_done", 100);
    chk("post_rst_first_grant", 32'(grant_log[0]), 32'd1);

    // three-consumer instance, everyone re-requesting as soon as released
    prev3 = 1'b0;
    n3 = 0;
    while (log3.size() < 5 && n3 < 300) begin
      @(posedge clk); #1;
      if (mem_read_valid3 && !prev3) log3.push_back(int'(grant_id3));
      prev3 = mem_read_valid3;
      for (int i = 0; i < 3; i++) rv3[i] = !consumer_read_ready3[i];
      n3++;
    end
    chk("n3_grant_count", 32'(log3.size() >= 5), 32'd1);
    if (log3.size() >= 5) begin
      chk("n3_g0", 32'(log3[0]), 32'd0);
      chk("n3_g1", 32'(log3[1]), 32'd1);
      chk("n3_g2", 32'(log3[2]), 32'd2);
      chk("n3_wrap", 32'(log3[3]), 32'd0);
      chk("n3_g4", 32'(log3[4]), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
